// File: rtl/machine_pkg.sv
// rtl/machine_pkg.sv - shared tags, widths and issue states for the machine drain
package machine_pkg;

  localparam logic [1:0] TAG_EMPTY = 2'b00;
  localparam logic [1:0] TAG_HELD  = 2'b10;
  localparam logic [1:0] TAG_BUSY  = 2'b01;

  localparam int REQ_W_DEFAULT = 63;
  localparam int RSP_W_DEFAULT = 93;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/machine_slot_pair.sv
// rtl/machine_slot_pair.sv - 2-entry in-order tagged FIFO with head retag
module machine_slot_pair
  import machine_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         retag,
  input  logic [1:0]   retag_tag,
  output logic [1:0]   count,
  output logic [1:0]   head_tag,
  output logic [W-1:0] head_data
);

  logic [W+1:0] slot [2];
  logic         head_ptr;
  logic         tail_ptr;

  assign head_tag  = slot[head_ptr][W+1:W];
  assign head_data = slot[head_ptr][W-1:0];

  // Callers never push into the head slot while retagging or popping it:
  // a push only lands on the head when the store is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0]  <= '0;
      slot[1]  <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        slot[tail_ptr] <= {TAG_HELD, push_data};
        tail_ptr       <= ~tail_ptr;
      end
      if (retag) begin
        slot[head_ptr][W+1:W] <= retag_tag;
      end
      if (pop) begin
        slot[head_ptr] <= '0;
        head_ptr       <= ~head_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/machine_drain.sv
// rtl/machine_drain.sv - drains service-queue work items to the evaluator; MACHINE_DRAIN_STATS_EN adds counters
module machine_drain
  import machine_pkg::*;
#(
  parameter int REQ_W = REQ_W_DEFAULT,
  parameter int RSP_W = RSP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REQ_W-1:0] in_data,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [REQ_W-1:0] req_data,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [RSP_W-1:0] rsp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RSP_W-1:0] out_data
`ifdef MACHINE_DRAIN_STATS_EN
  ,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      done_cnt
`endif
);

  state_t           state;
  logic [1:0]       req_count;
  logic [1:0]       req_head_tag;
  logic [REQ_W-1:0] req_head_data;
  logic [1:0]       res_count;
  logic [1:0]       res_head_tag;
  logic [RSP_W-1:0] res_head_data;

  logic req_push;
  logic req_fire;
  logic rsp_fire;
  logic out_fire;

  assign in_ready  = !rst && (req_count != 2'd2);
  assign req_valid = (state == REQ);
  assign rsp_ready = (state == WAIT) && (res_count != 2'd2);
  assign out_valid = (res_head_tag == TAG_HELD);
  assign req_data  = req_valid ? req_head_data : '0;
  assign out_data  = out_valid ? res_head_data : '0;

  assign req_push = in_valid && in_ready;
  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign out_fire = out_valid && out_ready;

  machine_slot_pair #(.W(REQ_W)) u_req_store (
    .clk       (clk),
    .rst       (rst),
    .push      (req_push),
    .push_data (in_data),
    .pop       (rsp_fire),
    .retag     (req_fire),
    .retag_tag (TAG_BUSY),
    .count     (req_count),
    .head_tag  (req_head_tag),
    .head_data (req_head_data)
  );

  machine_slot_pair #(.W(RSP_W)) u_res_store (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_fire),
    .push_data (rsp_data),
    .pop       (out_fire),
    .retag     (1'b0),
    .retag_tag (TAG_EMPTY),
    .count     (res_count),
    .head_tag  (res_head_tag),
    .head_data (res_head_data)
  );

  // A push into an empty store counts as a HELD head so the item is
  // presented on the very next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (req_head_tag == TAG_HELD || (req_push && req_count == 2'd0)) state <= REQ;
        REQ:  if (req_ready) state <= WAIT;
        WAIT: if (rsp_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MACHINE_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt <= 16'd0;
      done_cnt   <= 16'd0;
    end else begin
      if (req_fire && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
      if (out_fire && done_cnt != 16'hFFFF) done_cnt <= done_cnt + 16'd1;
    end
  end
`endif

endmodule
